// File: rtl/ahb_tcm_arbiter_if.sv
// Bus bundle between the SCR1 I/D AHB-Lite masters, the TCM arbiter and its RAM.
// slave = arbiter view, master = the side driving the AHB masters and the RAM model.
interface ahb_tcm_arbiter_if #(parameter int ADDR_W = 13);
  logic [31:0]       i_haddr;
  logic [1:0]        i_htrans;
  logic [2:0]        i_hsize;
  logic              i_hready;
  logic [31:0]       i_hrdata;
  logic              i_hresp;
  logic [31:0]       d_haddr;
  logic [1:0]        d_htrans;
  logic [2:0]        d_hsize;
  logic              d_hwrite;
  logic [31:0]       d_hwdata;
  logic              d_hready;
  logic [31:0]       d_hrdata;
  logic              d_hresp;
  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  i_haddr, i_htrans, i_hsize, d_haddr, d_htrans, d_hsize, d_hwrite, d_hwdata, ram_rdata,
    output i_hready, i_hrdata, i_hresp, d_hready, d_hrdata, d_hresp,
    output ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );

  modport master (
    output i_haddr, i_htrans, i_hsize, d_haddr, d_htrans, d_hsize, d_hwrite, d_hwdata, ram_rdata,
    input  i_hready, i_hrdata, i_hresp, d_hready, d_hrdata, d_hresp,
    input  ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ahb_tcm_arbiter.sv
// Shares one single-port 1-cycle TCM between the SCR1 I and D AHB-Lite ports.
// One FSM per port (array of instances) plus a round-robin grant that drives the RAM directly.
module ahb_tcm_arbiter_port #(
  parameter int          ADDR_W    = 13,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_8000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic              gnt,
  input  logic [31:0]       ram_rdata,
  output logic              req,
  output logic              hready,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic [ADDR_W+1:0] cap_addr,
  output logic [1:0]        cap_size,
  output logic              cap_write
);
  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_DONE = 3'd2, S_ERR1 = 3'd3, S_ERR2 = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              accept, err;
  logic              unused_htrans0;

  assign unused_htrans0 = htrans[0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    accept  = htrans[1] && (state_q == S_IDLE || state_q == S_DONE);
    err     = (haddr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]) || (hsize > 3'd2) ||
              (hsize == 3'd1 && haddr[0]) || (hsize == 3'd2 && haddr[1:0] != 2'b00);
    case (state_q)
      S_IDLE, S_DONE: state_d = accept ? (err ? S_ERR1 : S_REQ) : S_IDLE;
      S_REQ:          if (gnt) state_d = S_DONE;
      S_ERR1:         state_d = S_ERR2;
      S_ERR2:         state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
    if (accept) begin
      addr_d  = haddr[ADDR_W+1:0];
      size_d  = hsize[1:0];
      write_d = hwrite;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  assign req       = (state_q == S_REQ);
  assign hready    = !(state_q == S_REQ || state_q == S_ERR1);
  assign hresp     = (state_q == S_ERR1 || state_q == S_ERR2);
  // DONE is exactly the cycle after this port's grant, so ram_rdata belongs to it.
  assign hrdata    = (state_q == S_DONE && !write_q) ? ram_rdata : 32'h0;
  assign cap_addr  = addr_q;
  assign cap_size  = size_q;
  assign cap_write = write_q;
endmodule

module ahb_tcm_arbiter #(
  parameter int          ADDR_W    = 13,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_8000
) (
  input logic               clk,
  input logic               rst,
  ahb_tcm_arbiter_if.slave  bus
);
  localparam int NUM_PORTS = 2;  // 0 = I, 1 = D

  logic [NUM_PORTS-1:0][31:0]       haddr, hrdata;
  logic [NUM_PORTS-1:0][1:0]        htrans, cap_size;
  logic [NUM_PORTS-1:0][2:0]        hsize;
  logic [NUM_PORTS-1:0][ADDR_W+1:0] cap_addr;
  logic [NUM_PORTS-1:0]             hwrite, gnt, req, hready, hresp, cap_write;
  logic                             last_gnt_q, last_gnt_d;
  logic                             sel;
  logic [3:0]                       be;

  assign haddr  = {bus.d_haddr, bus.i_haddr};
  assign htrans = {bus.d_htrans, bus.i_htrans};
  assign hsize  = {bus.d_hsize, bus.i_hsize};
  assign hwrite = {bus.d_hwrite, 1'b0};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    ahb_tcm_arbiter_port #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_port (
      .clk(clk), .rst(rst), .haddr(haddr[g]), .htrans(htrans[g]), .hsize(hsize[g]),
      .hwrite(hwrite[g]), .gnt(gnt[g]), .ram_rdata(bus.ram_rdata), .req(req[g]),
      .hready(hready[g]), .hresp(hresp[g]), .hrdata(hrdata[g]), .cap_addr(cap_addr[g]),
      .cap_size(cap_size[g]), .cap_write(cap_write[g])
    );
  end

  // last_gnt_q = 1 means D was granted last, so I wins the next tie.
  always_comb begin
    gnt[0]     = req[0] && (!req[1] || last_gnt_q);
    gnt[1]     = req[1] && (!req[0] || !last_gnt_q);
    last_gnt_d = gnt[1] ? 1'b1 : (gnt[0] ? 1'b0 : last_gnt_q);
    sel        = gnt[1];
    be         = 4'h0;
    if (|gnt) begin
      if (!cap_write[sel]) be = 4'hF;
      else begin
        case (cap_size[sel])
          2'd0:    be = 4'b0001 << cap_addr[sel][1:0];
          2'd1:    be = 4'b0011 << cap_addr[sel][1:0];
          default: be = 4'hF;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_gnt_q <= 1'b1;
    else     last_gnt_q <= last_gnt_d;
  end

  assign bus.ram_en    = |gnt;
  assign bus.ram_we    = (|gnt) && cap_write[sel];
  assign bus.ram_be    = be;
  assign bus.ram_addr  = (|gnt) ? cap_addr[sel][ADDR_W+1:2] : '0;
  assign bus.ram_wdata = (gnt[1] && cap_write[1]) ? bus.d_hwdata : 32'h0;

  assign bus.i_hready = hready[0];
  assign bus.i_hresp  = hresp[0];
  assign bus.i_hrdata = hrdata[0];
  assign bus.d_hready = hready[1];
  assign bus.d_hresp  = hresp[1];
  assign bus.d_hrdata = hrdata[1];
endmodule
